decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered RV32I instruction decode stage with valid/ready handshakes on both sides. It sits between fetch and the register-read/execute stage.
- It splits fields, classifies the instruction type, generates the immediate, and performs full-field legality checking rather than opcode-only checking.
- Parametrised output buffering (pipeline register or 2-entry skid buffer), optional RV32M recognition, flush support, and a saturating illegal-instruction counter.

Parameters:
- PC_WIDTH, 32, width of the PC carried alongside each instruction.
- DEPTH, 2, output buffer entries; legal values are 1 (pipeline register) or 2 (skid buffer).
- ENABLE_M, 0, when 1, OPCODE_R with funct7=0000001 is legal and sets out_is_m.
- CNT_WIDTH, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  instruction word.
- in_pc  in  PC_WIDTH  PC of in_instr.
- out_valid  out  1  decoded entry available at the head.
- out_ready  in  1  downstream accepts the head entry.
- out_pc  out  PC_WIDTH  PC of the head entry.
- opcode  out  7  bits [6:0].
- rd_addr  out  5  bits [11:7].
- funct3  out  3  bits [14:12].
- rs1_addr  out  5  bits [19:15].
- rs2_addr  out  5  bits [24:20].
- funct7  out  7  bits [31:25].
- inst_type  out  4  type code from defines.v (TYPE_R/I/S/B/U/J/INVALID).
- immediate  out  32  sign-extended immediate.
- illegal  out  1  head entry is an illegal instruction.
- out_is_m  out  1  head entry is an M-extension op; always 0 when ENABLE_M=0.
- illegal_count  out  CNT_WIDTH  saturating count of illegal instructions accepted.

Behaviour:
- Reset: on a clock edge with rst=1, clear all entries. out_valid=0, all decoded data outputs=0, illegal_count=0. in_ready=0 while rst is high and 1 in the first cycle after rst deasserts.
- Transfer rules:
  - An input transfer happens when in_valid&&in_ready.
  - An output transfer happens when out_valid&&out_ready.
  - Outputs stay stable while out_valid&&!out_ready.
- Decode is combinational on in_instr; the result is captured into an entry on input transfer.
- Latency: one cycle. An instruction accepted into an empty stage at edge N appears with out_valid=1 in the cycle after edge N. There is no combinational in-to-out path.
- DEPTH=1:
  - in_ready = !out_valid || out_ready.
  - Simultaneous output and input transfer replaces the entry, giving full throughput.
- DEPTH=2:
  - in_ready is registered and equals !full.
  - Occupancy is 0, 1 or 2 entries.
  - In transfer only: occupancy +1. Out transfer only: occupancy −1. Both at once: occupancy unchanged and order preserved (FIFO).
  - Reaching 2 entries drops in_ready the next cycle. Input is never lost and never duplicated.
- Type mapping:
  - LUI, AUIPC → U.
  - JAL → J.
  - JALR, LOAD, OP-IMM, FENCE, SYSTEM → I.
  - BRANCH → B; STORE → S; OP → R.
- Immediates, with sign = bit 31:
  - I: sign-extend [31:20].
  - S: sign-extend {[31:25],[11:7]}.
  - B: sign-extend {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: sign-extend {[31],[19:12],[20],[30:21],0}.
  - R and illegal instructions: 0.
- Illegal when any of the following holds:
  - [1:0]≠11, or opcode not in the set above.
  - JALR with funct3≠000.
  - BRANCH with funct3 ∈ {010,011}.
  - LOAD with funct3 ∈ {011,110,111}.
  - STORE with funct3 ≥ 011.
  - OP-IMM with funct3=001 and funct7≠0, or funct3=101 and funct7 ∉ {0000000,0100000}.
  - OP with funct7 ∉ {0000000,0100000,(0000001 if ENABLE_M)}, or funct7=0100000 with funct3 ∉ {000,101}.
- For illegal entries: inst_type=TYPE_INVALID, immediate=0, out_is_m=0. Raw fields and PC still pass through, and the entry flows normally.
- illegal_count increments by 1 on each input transfer of an illegal instruction. It saturates at all-ones and is not cleared by flush.
- Flush:
  - Edge with flush=1 empties all entries; out_valid=0 next cycle.
  - in_ready is forced to 0 during a flush cycle, so no transfer occurs and illegal_count does not change.
  - A head entry presented with out_ready=1 in the flush cycle counts as consumed.
- Priority: rst > flush > normal operation.

Test Plan:
- Reset then in_instr=0x00500093 (addi x1,x0,5), out_ready=1 → next cycle out_valid=1, inst_type=TYPE_I, immediate=5, rd_addr=1, illegal=0.
- Branch 0xFE000EE3 (beq x0,x0,-4) → inst_type=TYPE_B, immediate=0xFFFFFFFC. JAL 0x0080006F → TYPE_J, immediate=8.
- DEPTH=2, out_ready=0, 3 back-to-back valids → 2 accepted, in_ready=0 from the cycle after the 2nd; release out_ready → entries emerge in order, then the 3rd is accepted.
- 0x02208033 (mul): ENABLE_M=0 → illegal=1, TYPE_INVALID, illegal_count=1; ENABLE_M=1 → illegal=0, out_is_m=1, TYPE_R.
- 0x00001067 (jalr with funct3=001) and 0x40001033 (funct7=0100000 with funct3=001) → both illegal, immediate=0, illegal_count increments per accept; force the count to max → holds at max.
- Two entries buffered, assert flush with in_valid=1 → next cycle out_valid=0, input not accepted, illegal_count unchanged. Assert rst mid-stream → out_valid=0, all outputs 0, in_ready=1 after release.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode stage with valid/ready on both sides
//   clk, rst (sync, active-high), flush
//   in_valid/in_ready/in_instr/in_pc      : fetch side
//   out_valid/out_ready/out_pc + fields   : head entry of the output buffer
//   inst_type, immediate, illegal, out_is_m, illegal_count (saturating)
//   Type codes: R=0 I=1 S=2 B=3 U=4 J=5 INVALID=15
module decode_stage #(
  parameter int PC_WIDTH  = 32,
  parameter int DEPTH     = 2,
  parameter int ENABLE_M  = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [PC_WIDTH-1:0]  in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PC_WIDTH-1:0]  out_pc,
  output logic [6:0]           opcode,
  output logic [4:0]           rd_addr,
  output logic [2:0]           funct3,
  output logic [4:0]           rs1_addr,
  output logic [4:0]           rs2_addr,
  output logic [6:0]           funct7,
  output logic [3:0]           inst_type,
  output logic [31:0]          immediate,
  output logic                 illegal,
  output logic                 out_is_m,
  output logic [CNT_WIDTH-1:0] illegal_count
);
  localparam logic [3:0] TYPE_R = 4'd0, TYPE_I = 4'd1, TYPE_S = 4'd2, TYPE_B = 4'd3;
  localparam logic [3:0] TYPE_U = 4'd4, TYPE_J = 4'd5, TYPE_INVALID = 4'd15;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23;
  localparam logic [6:0] OP_IMM = 7'h13, OP_OP = 7'h33, OP_FENCE = 7'h0f, OP_SYSTEM = 7'h73;
  localparam bit EN_M = ENABLE_M != 0;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         instr;
    logic [3:0]          typ;
    logic [31:0]         imm;
    logic                ill;
    logic                is_m;
  } ent_t;

  ent_t dec, e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic rdy_q, rdy_d;
  logic [CNT_WIDTH-1:0] ill_q, ill_d;
  logic push, pop;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [3:0] typ;
  logic [31:0] imm;
  logic bad, is_m;

  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];

  always_comb begin
    typ  = TYPE_INVALID;
    imm  = '0;
    bad  = 1'b0;
    is_m = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC: begin
        typ = TYPE_U;
        imm = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        typ = TYPE_J;
        imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: begin
        typ = TYPE_I;
        imm = {{20{in_instr[31]}}, in_instr[31:20]};
        bad = (op == OP_JALR && f3 != 3'b000) ||
              (op == OP_LOAD && (f3 == 3'b011 || f3[2:1] == 2'b11)) ||
              (op == OP_IMM && f3 == 3'b001 && f7 != 7'h00) ||
              (op == OP_IMM && f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
      end
      OP_STORE: begin
        typ = TYPE_S;
        imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        bad = f3 >= 3'b011;
      end
      OP_BRANCH: begin
        typ = TYPE_B;
        imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
        bad = f3[2:1] == 2'b01;
      end
      OP_OP: begin
        typ  = TYPE_R;
        is_m = EN_M && f7 == 7'h01;
        bad  = !(f7 == 7'h00 || f7 == 7'h20 || is_m) || (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101);
      end
      default: bad = 1'b1;
    endcase
    dec.pc    = in_pc;
    dec.instr = in_instr;
    dec.ill   = bad;
    dec.typ   = bad ? TYPE_INVALID : typ;
    dec.imm   = bad ? '0 : imm;
    dec.is_m  = !bad && is_m;
  end

  // DEPTH=1 passes ready through from downstream; DEPTH=2 uses the registered !full
  assign out_valid = cnt_q != 2'd0;
  assign in_ready  = !rst && !flush && (DEPTH == 1 ? (!out_valid || out_ready) : rdy_q);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Slot 0 is always the head; a pop shifts slot 1 forward, and the new entry
  // lands in the first slot left empty after that shift
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = flush ? 2'd0 : cnt_q + 2'(push) - 2'(pop);
    if (!flush && pop) e0_d = e1_q;
    if (!flush && push && cnt_q == 2'(pop)) e0_d = dec;
    if (!flush && push && cnt_q != 2'(pop)) e1_d = dec;
    rdy_d = cnt_d != 2'd2;
    ill_d = ill_q + CNT_WIDTH'(push && dec.ill && !(&ill_q));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
      rdy_q <= 1'b1;
      ill_q <= '0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
      rdy_q <= rdy_d;
      ill_q <= ill_d;
    end
  end

  assign out_pc        = e0_q.pc;
  assign opcode        = e0_q.instr[6:0];
  assign rd_addr       = e0_q.instr[11:7];
  assign funct3        = e0_q.instr[14:12];
  assign rs1_addr      = e0_q.instr[19:15];
  assign rs2_addr      = e0_q.instr[24:20];
  assign funct7        = e0_q.instr[31:25];
  assign inst_type     = e0_q.typ;
  assign immediate     = e0_q.imm;
  assign illegal       = e0_q.ill;
  assign out_is_m      = e0_q.is_m;
  assign illegal_count = ill_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: random and directed checks of two decode_stage configurations against a queue model
module tb_decode_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [3:0]  typ;
    logic [31:0] imm;
    logic        ill;
    logic        m;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic rdy_a, ov_a, il_a, m_a, rdy_b, ov_b, il_b, m_b;
  logic [31:0] pc_a, im_a, pc_b, im_b;
  logic [6:0] op_a, f7_a, op_b, f7_b;
  logic [4:0] rd_a, rs1_a, rs2_a, rd_b, rs1_b, rs2_b;
  logic [2:0] f3_a, f3_b;
  logic [3:0] ty_a, ty_b, cnt_a;
  logic [15:0] cnt_b;

  decode_stage #(.PC_WIDTH(32), .DEPTH(2), .ENABLE_M(0), .CNT_WIDTH(4)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov_a), .out_ready(out_ready),
    .out_pc(pc_a), .opcode(op_a), .rd_addr(rd_a), .funct3(f3_a), .rs1_addr(rs1_a),
    .rs2_addr(rs2_a), .funct7(f7_a), .inst_type(ty_a), .immediate(im_a),
    .illegal(il_a), .out_is_m(m_a), .illegal_count(cnt_a));

  decode_stage #(.PC_WIDTH(32), .DEPTH(1), .ENABLE_M(1), .CNT_WIDTH(16)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(ov_b), .out_ready(out_ready),
    .out_pc(pc_b), .opcode(op_b), .rd_addr(rd_b), .funct3(f3_b), .rs1_addr(rs1_b),
    .rs2_addr(rs2_b), .funct7(f7_b), .inst_type(ty_b), .immediate(im_b),
    .illegal(il_b), .out_is_m(m_b), .illegal_count(cnt_b));

  int total = 0, bad = 0;
  ent_t qa[$], qb[$];
  logic [3:0] ca;
  logic [15:0] cb;
  bit za, zb;
  logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0f, 7'h73};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sx(input logic [31:0] v, input int n);
    return v[n-1] ? (v | ~((32'd1 << n) - 32'd1)) : v;
  endfunction

  function automatic ent_t ref_dec(input logic [31:0] w, input bit em, input logic [31:0] pc);
    ent_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    e.pc = pc;
    e.instr = w;
    e.ill = 1'b0;
    e.m = 1'b0;
    e.imm = 32'd0;
    e.typ = 4'd15;
    case (w[6:0])
      7'h37, 7'h17: begin e.typ = 4'd4; e.imm = {w[31:12], 12'h000}; end
      7'h6f: begin e.typ = 4'd5; e.imm = sx({11'd0, w[31], w[19:12], w[20], w[30:21], 1'b0}, 21); end
      7'h67: begin e.typ = 4'd1; e.imm = sx({20'd0, w[31:20]}, 12); e.ill = f3 != 3'd0; end
      7'h03: begin e.typ = 4'd1; e.imm = sx({20'd0, w[31:20]}, 12); e.ill = f3 inside {3'd3, 3'd6, 3'd7}; end
      7'h13: begin
        e.typ = 4'd1;
        e.imm = sx({20'd0, w[31:20]}, 12);
        e.ill = (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20}));
      end
      7'h0f, 7'h73: begin e.typ = 4'd1; e.imm = sx({20'd0, w[31:20]}, 12); end
      7'h23: begin e.typ = 4'd2; e.imm = sx({20'd0, w[31:25], w[11:7]}, 12); e.ill = f3 >= 3'd3; end
      7'h63: begin e.typ = 4'd3; e.imm = sx({19'd0, w[31], w[7], w[30:25], w[11:8], 1'b0}, 13); e.ill = f3 inside {3'd2, 3'd3}; end
      7'h33: begin
        e.typ = 4'd0;
        e.m = em && f7 == 7'h01;
        e.ill = !(f7 == 7'h00 || f7 == 7'h20 || e.m) || (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5}));
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e.typ = 4'd15; e.imm = 32'd0; e.m = 1'b0; end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0] f7s [4];
    w = $urandom;
    f7s[0] = 7'h00; f7s[1] = 7'h20; f7s[2] = 7'h01; f7s[3] = w[31:25];
    w[31:25] = f7s[$urandom_range(0, 3)];
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 10)];
    return w;
  endfunction

  task automatic check_inst(input string n, input bit has, input bit zr, input ent_t h,
                            input logic ov, input logic [31:0] pc, input logic [31:0] ins,
                            input logic [3:0] ty, input logic [31:0] im, input logic il, input logic m);
    check({n, ".valid"}, ov, has);
    if (has || zr) begin
      check({n, ".pc"}, pc, has ? h.pc : 32'd0);
      check({n, ".instr"}, ins, has ? h.instr : 32'd0);
      check({n, ".type"}, ty, has ? h.typ : 4'd0);
      check({n, ".imm"}, im, has ? h.imm : 32'd0);
      check({n, ".illegal"}, il, has ? h.ill : 1'b0);
      check({n, ".is_m"}, m, has ? h.m : 1'b0);
    end
  endtask

  task automatic cycle(input logic r, input logic f, input logic v, input logic [31:0] w, input logic orr);
    logic era, erb;
    ent_t ha, hb;
    rst = r; flush = f; in_valid = v; in_instr = w; in_pc = $urandom; out_ready = orr;
    @(negedge clk);
    era = !r && !f && qa.size() < 2;
    erb = !r && !f && (qb.size() == 0 || orr);
    ha = qa.size() > 0 ? qa[0] : '0;
    hb = qb.size() > 0 ? qb[0] : '0;
    check("a.in_ready", rdy_a, era);
    check("b.in_ready", rdy_b, erb);
    check_inst("a", qa.size() > 0, za, ha, ov_a, pc_a, {f7_a, rs2_a, rs1_a, f3_a, rd_a, op_a}, ty_a, im_a, il_a, m_a);
    check_inst("b", qb.size() > 0, zb, hb, ov_b, pc_b, {f7_b, rs2_b, rs1_b, f3_b, rd_b, op_b}, ty_b, im_b, il_b, m_b);
    check("a.count", cnt_a, ca);
    check("b.count", cnt_b, cb);
    @(posedge clk);
    if (r) begin
      qa.delete(); qb.delete(); ca = '0; cb = '0; za = 1; zb = 1;
    end else if (f) begin
      qa.delete(); qb.delete();
    end else begin
      if (qa.size() > 0 && orr) void'(qa.pop_front());
      if (qb.size() > 0 && orr) void'(qb.pop_front());
      if (v && era) begin
        qa.push_back(ref_dec(w, 0, in_pc)); za = 0;
        if (qa[$].ill && ca != 4'hf) ca++;
      end
      if (v && erb) begin
        qb.push_back(ref_dec(w, 1, in_pc)); zb = 0;
        if (qb[$].ill && cb != 16'hffff) cb++;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
    ca = '0; cb = '0; za = 1; zb = 1;
    @(posedge clk); @(posedge clk); #1;
    cycle(0, 0, 1, 32'h00500093, 1);
    check("addi.valid", ov_a, 1); check("addi.type", ty_a, 4'd1); check("addi.imm", im_a, 32'd5);
    check("addi.rd", rd_a, 5'd1); check("addi.illegal", il_a, 0);
    cycle(0, 0, 1, 32'hFE000EE3, 1);
    check("beq.type", ty_a, 4'd3); check("beq.imm", im_a, 32'hFFFFFFFC);
    cycle(0, 0, 1, 32'h0080006F, 1);
    check("jal.type", ty_a, 4'd5); check("jal.imm", im_a, 32'd8);
    cycle(0, 0, 0, 32'd0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 32'h00100113 + (i << 20), 0);
    check("bp.in_ready", rdy_a, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'h00300193, 1);
    cycle(0, 0, 1, 32'h02208033, 1);
    check("mul.a.illegal", il_a, 1); check("mul.a.type", ty_a, 4'd15); check("mul.a.count", cnt_a, 4'd1);
    check("mul.b.illegal", il_b, 0); check("mul.b.is_m", m_b, 1); check("mul.b.type", ty_b, 4'd0);
    cycle(0, 0, 1, 32'h00001067, 1);
    check("jalr3.imm", im_a, 32'd0); check("jalr3.count", cnt_a, 4'd2);
    cycle(0, 0, 1, 32'h40001033, 1);
    check("sub1.imm", im_a, 32'd0); check("sub1.count", cnt_a, 4'd3);
    for (int i = 0; i < 20; i++) cycle(0, 0, 1, 32'h40001033, 1);
    check("sat.count", cnt_a, 4'hf);
    cycle(0, 0, 1, 32'h00500093, 0);
    cycle(0, 0, 1, 32'h00000013, 0);
    cycle(0, 1, 1, 32'h00001067, 0);
    check("flush.valid", ov_a, 0); check("flush.count", cnt_a, 4'hf);
    cycle(0, 0, 1, 32'h00500093, 0);
    cycle(1, 0, 1, 32'h00500093, 1);
    check("rst.valid", ov_a, 0); check("rst.imm", im_a, 32'd0); check("rst.count", cnt_a, 4'd0);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 7,
            rand_instr(), $urandom_range(0, 9) < 6);
    cycle(0, 0, 0, 32'd0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
